// File: rtl/connect4_pkg.sv
// Purpose : shared types, board geometry and small board helpers for the piece drop path.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    // Row 0 is the top of the board, row ROWS-1 the bottom; each cell holds a piece code.
    typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FALL,
        PLACE,
        DONE,
        ERR
    } drop_state_t;

    // Reads one cell; coordinates off the board read as EMPTY so callers never index out of range.
    function automatic logic [1:0] cell_at(board_t b, logic [2:0] row, logic [2:0] col);
        logic [1:0] v;
        v = EMPTY;
        if ((row < 3'(ROWS)) && (col < 3'(COLS))) begin
            v = b[row][col];
        end
        return v;
    endfunction

    function automatic logic is_player(logic [1:0] p);
        return (p == P1) || (p == P2);
    endfunction

    // The board is full exactly when every top-row cell is occupied.
    function automatic logic top_row_full(board_t b);
        logic full;
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (b[0][c] == EMPTY) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/piece_drop_controller_if.sv
// Purpose : groups the move request, board and status signals of the piece drop controller.
// Latency : n/a (wiring only).
// Backpressure: requests are only taken while busy is low; nothing is queued.
// Ports   : master = move source / observer (drives start, col, player, clear);
//           slave  = controller (drives board, status, animation and placement outputs).
interface piece_drop_controller_if;
    import connect4_pkg::*;

    logic       start;
    logic [2:0] col;
    logic [1:0] player;
    logic       clear;

    board_t     board;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] placed_row;
    logic [2:0] placed_col;
    logic       anim_active;
    logic [2:0] anim_row;
    logic       board_full;

    modport master (
        output start, col, player, clear,
        input  board, busy, done, error, placed_row, placed_col,
               anim_active, anim_row, board_full
    );

    modport slave (
        input  start, col, player, clear,
        output board, busy, done, error, placed_row, placed_col,
               anim_active, anim_row, board_full
    );

endinterface

// File: rtl/fall_timer.sv
// Purpose : paces the falling piece; tick pulses once every FALL_TICKS enabled cycles.
// Latency : tick is combinational on the last count of each row period.
// Backpressure: none; clr holds the count at zero, en advances it.
// Ports   : clk, rst (async active-low), clr (sync restart), en (count), tick (row period elapsed).
module fall_timer #(
    parameter int FALL_TICKS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(FALL_TICKS - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Wraps to zero on its own at the end of each period, so the next row starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piece_drop_controller.sv
// Purpose : owns the 6x7 board, accepts one drop at a time, animates its fall and writes it.
// Latency : done pulses (r+1)*FALL_TICKS+3 sample cycles after the accepting edge (r = landing row).
// Backpressure: start/clear are only honoured while idle; anything arriving while busy is dropped.
// Ports   : clk, rst (async active-low), bus (slave side of piece_drop_controller_if).
module piece_drop_controller
    import connect4_pkg::*;
#(
    parameter int FALL_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    piece_drop_controller_if.slave  bus
);

    drop_state_t state_q, state_d;
    logic [2:0]  col_q, col_d;
    logic [1:0]  player_q, player_d;
    logic [2:0]  anim_row_q, anim_row_d;
    logic [2:0]  placed_row_q, placed_row_d;
    logic [2:0]  placed_col_q, placed_col_d;
    board_t      board_q, board_d;

    logic        tmr_clr;
    logic        tmr_en;
    logic        tick;

    fall_timer #(
        .FALL_TICKS (FALL_TICKS)
    ) u_fall_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            player_q     <= '0;
            anim_row_q   <= '0;
            placed_row_q <= '0;
            placed_col_q <= '0;
            board_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            player_q     <= player_d;
            anim_row_q   <= anim_row_d;
            placed_row_q <= placed_row_d;
            placed_col_q <= placed_col_d;
            board_q      <= board_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        player_d     = player_q;
        anim_row_d   = anim_row_q;
        placed_row_d = placed_row_q;
        placed_col_d = placed_col_q;
        board_d      = board_q;
        tmr_clr      = 1'b1;
        tmr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                // A drop request takes priority over a clear arriving in the same cycle.
                if (bus.start) begin
                    col_d    = bus.col;
                    player_d = bus.player;
                    state_d  = CHECK;
                end else if (bus.clear) begin
                    board_d = '0;
                end
            end

            CHECK: begin
                if ((col_q > 3'd6) || !is_player(player_q) ||
                    (cell_at(board_q, 3'd0, col_q) != EMPTY)) begin
                    state_d = ERR;
                end else begin
                    anim_row_d = '0;
                    state_d    = FALL;
                end
            end

            FALL: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // At the end of each row period, stop on the floor or on top of a piece,
                // otherwise move down one row.
                if (tick) begin
                    if ((anim_row_q == 3'd5) ||
                        (cell_at(board_q, anim_row_q + 3'd1, col_q) != EMPTY)) begin
                        state_d = PLACE;
                    end else begin
                        anim_row_d = anim_row_q + 3'd1;
                    end
                end
            end

            PLACE: begin
                board_d[anim_row_q][col_q] = player_q;
                placed_row_d               = anim_row_q;
                placed_col_d               = col_q;
                state_d                    = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.board       = board_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.error       = (state_q == ERR);
    assign bus.anim_active = (state_q == FALL);
    assign bus.anim_row    = anim_row_q;
    assign bus.placed_row  = placed_row_q;
    assign bus.placed_col  = placed_col_q;
    assign bus.board_full  = top_row_full(board_q);

endmodule

// File: doc/piece_drop_controller.md
Name: piece_drop_controller

Overview:
- Owns the 6x7 Connect Four board register and executes one move at a time.
- Accepts a column and a player, animates the piece falling row by row, and writes it into the lowest empty cell of that column.
- Sits directly downstream of the move source: Random_Move_Generator's valid_col/valid, or the human input path.
- Its board output feeds back to the move generator, the win checker and the VGA renderer.

Parameters:
- FALL_TICKS, 1, clock cycles the falling piece spends on each row. Must be >= 1. Use 1 in simulation; use a large value in hardware for a visible animation.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a drop; sampled only in IDLE
- col  in  3  target column, 0..6
- player  in  2  piece code: 01 = player 1, 10 = player 2
- clear  in  1  wipe the board; honoured only in IDLE
- board  out  2 x [0:5][0:6]  registered board; row 0 is the top, row 5 the bottom, 00 = empty
- busy  out  1  high from start accept until the cycle after done/error
- done  out  1  one-cycle pulse: piece written
- error  out  1  one-cycle pulse: request rejected
- placed_row  out  3  row where the last piece landed
- placed_col  out  3  column of the last piece
- anim_active  out  1  high while in FALL
- anim_row  out  3  current row of the falling piece
- board_full  out  1  combinational from registers; high when all seven row-0 cells are non-empty

Behaviour:
- Reset (rst=0, asynchronous): all board cells 00; state IDLE; busy/done/error/anim_active 0; placed_row, placed_col, anim_row 0.
- Reset mid-operation aborts the move; no partial write.
- IDLE:
  - start=1: latch col and player, busy=1, go to CHECK.
  - start=0 and clear=1: all cells 00 on the next edge.
  - start and clear both high: start wins, clear is dropped.
- CHECK (1 cycle): if col > 6, or player not in {01,10}, or board[0][col] != 00, go to ERR. Otherwise anim_row=0, tick counter=0, go to FALL.
- FALL:
  - Counter increments every cycle.
  - When it reaches FALL_TICKS-1: if anim_row==5 or board[anim_row+1][col] != 00, go to PLACE. Otherwise anim_row++ and the counter resets.
- PLACE (1 cycle): board[anim_row][col] <= player, placed_row <= anim_row, placed_col <= col, then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. busy drops on the IDLE cycle.
- ERR (1 cycle): error=1, board unchanged, then go to IDLE.
- Latency: for landing row r, done is high exactly (r+1)*FALL_TICKS + 3 cycles after the edge that accepted start. With FALL_TICKS=1 on an empty column, that is 9 cycles.
- start or clear while busy: ignored, no queueing.
- col and player may change after acceptance; the latched copies are used.
- Only one cell changes per accepted move.

Decomposition:
- Package connect4_pkg holds:
  - ROWS=6 and COLS=7
  - cell_t enum: EMPTY=2'b00, P1=2'b01, P2=2'b10
  - board_t typedef
  - drop_state_t enum: IDLE, CHECK, FALL, PLACE, DONE, ERR
- One natural sub-module: fall_timer (parameter FALL_TICKS, inputs clk, rst, clr, en, output tick). The FSM and board storage stay in the top module.

Test Plan:
- Empty board, FALL_TICKS=1, start col=3 player=01 → anim_row steps 0..5; done 9 cycles after acceptance; board[5][3]=01; placed_row=5; all other cells 00.
- After the previous move, drop col=3 player=10 → done after 8 cycles; board[4][3]=10; board[5][3] still 01.
- Column 0 filled with six drops, then a seventh start col=0 → error pulse after CHECK; no done; board unchanged. Fill the remaining columns → board_full=1.
- start col=7, then start with player=00 → error both times; board unchanged.
- start asserted while busy, and clear asserted while busy → ignored; the in-flight drop completes normally. Then clear in IDLE → all 42 cells 00 on the next edge.
- rst pulsed low mid-FALL with FALL_TICKS=4 → outputs go to reset values immediately, with no clock edge needed; the target cell stays 00; a following drop works normally.
